// File: rtl/alu_seq_ctrl_if.sv
// Issue handshake between a requester and the ALU sequencing controller.
// The requester drives the opcode and register addresses and holds them
// with in_valid until it sees in_ready.
interface alu_seq_ctrl_if #(
   parameter int ADDR_W = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_oc;
   logic [ADDR_W-1:0] in_dst;
   logic [ADDR_W-1:0] in_src_a;
   logic [ADDR_W-1:0] in_src_b;

   modport master (
      output in_valid,
      output in_oc,
      output in_dst,
      output in_src_a,
      output in_src_b,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_oc,
      input  in_dst,
      input  in_src_a,
      input  in_src_b,
      output in_ready
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Issue/writeback sequencer around an external combinational ALU.
// Operands come from a small register file, are registered onto the ALU
// inputs at accept, and the ALU result is written back one edge later.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; operands latched on accept
// S_EXEC | ALU inputs stable; result written back at the closing edge
// S_WB   | writeback done; done/err pulse is registered at this edge
module alu_seq_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int REG_COUNT  = 4,
   parameter int ADDR_W     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_seq_ctrl_if.slave         req,
   input  logic                  ld_en,
   input  logic [ADDR_W-1:0]     ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [2:0]            alu_oc,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_f,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           op_count
);

   localparam logic [2:0] OC_DIV = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t                  state;
   logic [ADDR_W-1:0]       dst_q;
   logic                    dz_q;
   logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
   logic                    div_zero;
   logic                    wb_en;

   // Divide by zero suppresses the writeback and the op count.
   assign div_zero = (alu_oc == OC_DIV) && (alu_b == '0);
   assign wb_en    = (state == S_EXEC) && !div_zero;

   // Ready is held low throughout reset, not just after the first edge.
   assign req.in_ready = (state == S_IDLE) && !rst;

   assign rd_data = regs[rd_addr];

   // Register file: per-entry decode, writeback has priority over the load port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (wb_en && (dst_q == ADDR_W'(i))) begin
               regs[i] <= alu_f;
            end else if (ld_en && (ld_addr == ADDR_W'(i))) begin
               regs[i] <= ld_data;
            end
         end
      end
   end

   // Sequencer: operand capture, op counting and the retire pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         alu_oc   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         dst_q    <= '0;
         dz_q     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         op_count <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req.in_valid) begin
                  alu_oc <= req.in_oc;
                  dst_q  <= req.in_dst;
                  alu_a  <= regs[req.in_src_a];
                  alu_b  <= regs[req.in_src_b];
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               dz_q <= div_zero;
               if (!div_zero) begin
                  op_count <= op_count + 16'd1;
               end
               state <= S_WB;
            end
            S_WB: begin
               done  <= 1'b1;
               err   <= dz_q;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
